// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller/scheduler.
package intc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned GEN_BIT  = 15;
  localparam int unsigned BUSY_BIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2,
    SERV = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PEND   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_ACTV   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_SWTRIG = 2'd3;

endpackage

// File: rtl/intc_prio_enc.sv
// Winner selection among eligible sources. Build option INTC_PRIO_ROTATE_EN
// switches from fixed lowest-index priority to round-robin starting at ptr.
module intc_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned VEC_W = 2
) (
  input  logic [N_SRC-1:0] elig,
`ifdef INTC_PRIO_ROTATE_EN
  input  logic [VEC_W-1:0] ptr,
`endif
  output logic [VEC_W-1:0] winner,
  output logic             any
);

  assign any = |elig;

`ifdef INTC_PRIO_ROTATE_EN
  // Scan offsets downward so the nearest eligible index at/after ptr is assigned last.
  always_comb begin
    winner = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      logic [VEC_W-1:0] idx;
      idx = VEC_W'((32'(ptr) + 32'(k)) % N_SRC);
      if (elig[idx]) winner = idx;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) winner = VEC_W'(i);
    end
  end
`endif

endmodule

// File: rtl/intc_sched.sv
// Interrupt controller/scheduler: edge capture, masking, arbitration and the
// CPU ack/EOI handshake behind a zero-wait register block. Option: INTC_PRIO_ROTATE_EN.
module intc_sched
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned VEC_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdy,
  input  logic [N_SRC-1:0]  i_irq,
  output logic              o_cpu_irq,
  output logic [VEC_W-1:0]  o_vector,
  input  logic              i_cpu_ack,
  input  logic              i_cpu_eoi
);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic               gen_q, gen_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   irq_q;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [N_SRC-1:0]   elig, elig_d;
  logic [N_SRC-1:0]   w1c, swtrig, ack_clr;
  logic               wr, rd, ack_take;
  logic [VEC_W-1:0]   winner;
  logic               any;
  logic               unused_wdata;

  assign wr           = i_sel & i_we;
  assign rd           = i_sel & i_re;
  assign o_rdy        = i_sel;
  assign unused_wdata = ^i_wdata;

`ifdef INTC_PRIO_ROTATE_EN
  logic [VEC_W-1:0] ptr_q, ptr_d;

  intc_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio (
    .elig   (elig),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (ack_take) ptr_d = (vec_q == VEC_W'(N_SRC - 1)) ? '0 : vec_q + VEC_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  intc_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio (
    .elig   (elig),
    .winner (winner),
    .any    (any)
  );
`endif

  // Register writes and pending update; a new set beats any same-cycle clear.
  always_comb begin
    mask_d   = mask_q;
    gen_d    = gen_q;
    w1c      = '0;
    swtrig   = '0;
    ack_clr  = '0;
    ack_take = (state_q == REQ) && i_cpu_ack;
    if (wr && i_addr == ADDR_CTRL) begin
      mask_d = i_wdata[N_SRC-1:0];
      gen_d  = i_wdata[GEN_BIT];
    end
    if (wr && i_addr == ADDR_PEND)   w1c    = i_wdata[N_SRC-1:0];
    if (wr && i_addr == ADDR_SWTRIG) swtrig = i_wdata[N_SRC-1:0];
    if (ack_take) ack_clr[vec_q] = 1'b1;
    pend_d = (pend_q & ~w1c & ~ack_clr) | (i_irq & ~irq_q) | swtrig;
    elig   = pend_q & mask_q & {N_SRC{gen_q}};
    elig_d = pend_d & mask_d & {N_SRC{gen_d}};
  end

  // IDLE and REQ look at the post-edge eligibility so a new request or a
  // withdrawal takes effect on the same edge the register/pending change lands.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (|elig_d) state_d = ARB;
      ARB: begin
        if (any) begin
          vec_d   = winner;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_cpu_ack)          state_d = SERV;
        else if (!elig_d[vec_q]) state_d = IDLE;
      end
      SERV:    if (i_cpu_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      gen_q     <= 1'b0;
      pend_q    <= '0;
      irq_q     <= '0;
      vec_q     <= '0;
      o_cpu_irq <= 1'b0;
      o_vector  <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      gen_q     <= gen_d;
      pend_q    <= pend_d;
      irq_q     <= i_irq;
      vec_q     <= vec_d;
      o_cpu_irq <= (state_d == REQ);
      o_vector  <= (state_d == REQ || state_d == SERV) ? vec_d : '0;
    end
  end

  // Zero-wait readback; ACTV reports the presented vector (0 when not busy).
  always_comb begin
    o_rdata = '0;
    if (rd) begin
      case (i_addr)
        ADDR_CTRL: begin
          o_rdata[N_SRC-1:0] = mask_q;
          o_rdata[GEN_BIT]   = gen_q;
        end
        ADDR_PEND: o_rdata[N_SRC-1:0] = pend_q;
        ADDR_ACTV: begin
          o_rdata[BUSY_BIT]  = (state_q == REQ) || (state_q == SERV);
          o_rdata[VEC_W-1:0] = o_vector;
        end
        default: o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_sched.sv
// Scoreboard bench for intc_sched: directed scenarios plus randomized traffic
// checked against a transaction-level model of the controller.
module tb_intc_sched;

  localparam int NS = 4;
`ifdef INTC_PRIO_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, we = 1'b0, re = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        rdy;
  logic [3:0]  irq = '0;
  logic        cpu_irq;
  logic [1:0]  vector;
  logic        ack = 1'b0, eoi = 1'b0;

  intc_sched #(.N_SRC(4), .VEC_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_we(we), .i_re(re),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_rdy(rdy),
    .i_irq(irq), .o_cpu_irq(cpu_irq), .o_vector(vector),
    .i_cpu_ack(ack), .i_cpu_eoi(eoi)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0=idle 1=arbitrating 2=requesting 3=in service
  typedef struct { int vec; int cyc; } grant_t;
  grant_t     grant_q[$];
  logic [15:0] rd_q[$];
  int         m_phase, m_vec, m_ptr;
  bit [3:0]   m_pend, m_mask, m_last_irq;
  bit         m_gen;

  function automatic void model_reset();
    m_phase = 0; m_vec = 0; m_ptr = 0;
    m_pend = '0; m_mask = '0; m_last_irq = '0; m_gen = 1'b0;
  endfunction

  function automatic int pick(input bit [3:0] e, input int start);
    for (int k = 0; k < NS; k++) begin
      int idx;
      idx = (start + k) % NS;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int m_outvec();
    return (m_phase == 2 || m_phase == 3) ? m_vec : 0;
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      2'd0: begin r[3:0] = m_mask; r[15] = m_gen; end
      2'd1: r[3:0] = m_pend;
      2'd2: begin r[15] = (m_phase == 2 || m_phase == 3); r[1:0] = 2'(m_outvec()); end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance the model by one clock using the inputs that the coming edge will sample.
  function automatic void model_step();
    bit [3:0] pend_n, mask_n, now_e, next_e;
    bit       gen_n, acked;
    int       w;
    grant_t   g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acked  = (m_phase == 2) && ack;
    mask_n = m_mask;
    gen_n  = m_gen;
    if (sel && we && addr == 2'd0) begin mask_n = wdata[3:0]; gen_n = wdata[15]; end
    pend_n = m_pend;
    if (acked) pend_n[m_vec] = 1'b0;
    if (sel && we && addr == 2'd1) pend_n = pend_n & ~wdata[3:0];
    pend_n = pend_n | (irq & ~m_last_irq);
    if (sel && we && addr == 2'd3) pend_n = pend_n | wdata[3:0];
    now_e  = m_gen ? (m_pend & m_mask) : 4'b0;
    next_e = gen_n ? (pend_n & mask_n) : 4'b0;
    case (m_phase)
      0: if (next_e != 0) m_phase = 1;
      1: begin
        w = pick(now_e, ROT ? m_ptr : 0);
        if (w >= 0) begin
          m_vec = w; m_phase = 2;
          g.vec = w; g.cyc = cyc + 1;
          grant_q.push_back(g);
        end else m_phase = 0;
      end
      2: begin
        if (acked) begin
          m_phase = 3;
          m_ptr = (m_vec + 1) % NS;
        end else if (!next_e[m_vec]) m_phase = 0;
      end
      default: if (eoi) m_phase = 0;
    endcase
    m_pend = pend_n; m_mask = mask_n; m_gen = gen_n; m_last_irq = irq;
  endfunction

  // Monitor: compares every presented output against the model / scoreboard.
  logic prev_irq = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    grant_t g;
    check("rdy", int'(rdy), int'(sel));
    if (sel && re) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        check("rdata", int'(rdata), int'(e));
      end
    end else check("rdata_idle", int'(rdata), 0);
    check("irq_level", int'(cpu_irq), int'(m_phase == 2));
    check("vector", int'(vector), m_outvec());
    if (cpu_irq && !prev_irq) begin
      if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
      else begin
        g = grant_q.pop_front();
        check("grant_vec", int'(vector), g.vec);
        check("grant_cycle", cyc, g.cyc);
      end
    end
    prev_irq = cpu_irq;
  end

  task automatic tick();
    @(negedge clk); #1;
    model_step();
    @(posedge clk); #1;
    sel = 0; we = 0; re = 0; addr = '0; wdata = '0; ack = 0; eoi = 0; irq = '0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
  endtask

  task automatic rd_exp(input logic [1:0] a, input logic [15:0] exp);
    sel = 1; re = 1; addr = a;
    rd_q.push_back(exp);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    grant_q.delete();
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp5[4];
    int w;
    logic [15:0] d;
    if (ROT) begin exp5[0] = 0; exp5[1] = 1; exp5[2] = 0; exp5[3] = 1; end
    else     begin exp5[0] = 0; exp5[1] = 0; exp5[2] = 0; exp5[3] = 0; end
    model_reset();

    // Reset state
    do_reset();
    check("rst_irq", int'(cpu_irq), 0);
    check("rst_vec", int'(vector), 0);
    rd_exp(2'd0, 16'h0000); tick();
    rd_exp(2'd1, 16'h0000); tick();
    rd_exp(2'd2, 16'h0000); tick();
    rd_exp(2'd3, 16'h0000); tick();

    // 1: single source, latency and ACTV readback
    wr_reg(2'd0, 16'h8003); tick();
    irq = 4'b0010; tick();
    check("t1_arb_irq", int'(cpu_irq), 0);
    tick();
    check("t1_irq", int'(cpu_irq), 1);
    check("t1_vec", int'(vector), 1);
    rd_exp(2'd2, 16'h8001); tick();
    ack = 1; tick();
    check("t1_serv_irq", int'(cpu_irq), 0);
    check("t1_serv_vec", int'(vector), 1);
    eoi = 1; tick();
    check("t1_idle_vec", int'(vector), 0);

    // 2: two simultaneous sources, lower index first, next follows EOI by 2 cycles
    do_reset();
    wr_reg(2'd0, 16'h8005); irq = 4'b0101; tick();
    tick();
    check("t2_vec0", int'(vector), 0);
    ack = 1; tick();
    rd_exp(2'd1, 16'h0004); tick();
    eoi = 1; tick();
    check("t2_after_eoi", int'(cpu_irq), 0);
    tick();
    check("t2_arb", int'(cpu_irq), 0);
    tick();
    check("t2_irq2", int'(cpu_irq), 1);
    check("t2_vec2", int'(vector), 2);

    // 3: globally enabled but masked source stays pending until unmasked
    do_reset();
    wr_reg(2'd0, 16'h8000); tick();
    irq = 4'b1000; tick();
    tick();
    check("t3_masked", int'(cpu_irq), 0);
    rd_exp(2'd1, 16'h0008); tick();
    wr_reg(2'd0, 16'h8008); tick();
    tick();
    check("t3_irq", int'(cpu_irq), 1);
    check("t3_vec", int'(vector), 3);

    // 4: W1C while requesting withdraws the request
    do_reset();
    wr_reg(2'd0, 16'h8002); irq = 4'b0010; tick();
    tick();
    check("t4_req", int'(cpu_irq), 1);
    wr_reg(2'd1, 16'h0002); tick();
    check("t4_withdraw", int'(cpu_irq), 0);
    rd_exp(2'd2, 16'h0000); tick();

    // 5: two permanently re-triggered sources
    do_reset();
    wr_reg(2'd0, 16'h8003); tick();
    wr_reg(2'd3, 16'h0003); tick();
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!cpu_irq && w < 10) begin tick(); w++; end
      check("t5_req_seen", int'(cpu_irq), 1);
      check("t5_order", int'(vector), exp5[g]);
      ack = 1; wr_reg(2'd3, 16'h0003); tick();
      eoi = 1; tick();
    end

    // 6: asynchronous reset while in service
    do_reset();
    wr_reg(2'd0, 16'h8004); irq = 4'b0110; tick();
    tick();
    ack = 1; tick();
    check("t6_serv_vec", int'(vector), 2);
    #1 rst_n = 0; model_reset(); grant_q.delete();
    #1;
    check("t6_rst_irq", int'(cpu_irq), 0);
    check("t6_rst_vec", int'(vector), 0);
    sel = 1; re = 1; addr = 2'd0; #1;
    check("t6_rst_ctrl", int'(rdata), 0);
    addr = 2'd1; #1;
    check("t6_rst_pend", int'(rdata), 0);
    addr = 2'd2; #1;
    check("t6_rst_actv", int'(rdata), 0);
    sel = 0; re = 0; addr = '0;
    tick();
    rst_n = 1; tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      if (m_phase == 2 && $urandom_range(0, 2) == 0) ack = 1;
      if (m_phase == 3 && $urandom_range(0, 2) == 0) eoi = 1;
      if ($urandom_range(0, 19) == 0) ack = 1;
      if ($urandom_range(0, 19) == 0) eoi = 1;
      d = 16'($urandom);
      case ($urandom_range(0, 15))
        0: begin d[15] = ($urandom_range(0, 3) != 0); wr_reg(2'd0, d); end
        1: wr_reg(2'd1, d);
        2: wr_reg(2'd3, d & 16'h000F);
        3, 4, 5: begin
          addr = 2'($urandom);
          rd_exp(addr, m_read(addr));
        end
        default: ;
      endcase
      tick();
    end
    tick();
    @(negedge clk); #2;
    check("sb_grant_drain", grant_q.size(), 0);
    check("sb_read_drain", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
